// File: rtl/result_byte_deser_if.sv
// Byte-stream and result-handshake bundle for result_byte_deser.
// master = deserializer side, slave = byte source / host side.
interface result_byte_deser_if;
  logic [7:0]  byte_in;
  logic        byte_vld;
  logic        sign_in;
  logic [63:0] res_data;
  logic        res_sign;
  logic        res_valid;
  logic        res_ready;
  logic        busy;
  logic        frame_err;
  logic        ovf;

  modport master (
    input  byte_in, byte_vld, sign_in, res_ready,
    output res_data, res_sign, res_valid, busy, frame_err, ovf
  );

  modport slave (
    output byte_in, byte_vld, sign_in, res_ready,
    input  res_data, res_sign, res_valid, busy, frame_err, ovf
  );
endinterface

// File: rtl/result_byte_deser.sv
// Reassembles the 8-bit result stream into words and queues them for the host.
// Optional macro RESULT_DESER_STATS_EN adds saturating frame_cnt / drop_cnt outputs.
module result_byte_deser #(
  parameter int BYTES_PER_WORD = 8,
  parameter int TIMEOUT_CYC    = 64,
  parameter int QDEPTH         = 2
) (
  input  logic                clk,
  input  logic                reset,
  result_byte_deser_if.master bus
`ifdef RESULT_DESER_STATS_EN
  ,
  output logic [15:0]         frame_cnt,
  output logic [15:0]         drop_cnt
`endif
);

  localparam int W  = 8 * BYTES_PER_WORD;
  localparam int CW = $clog2(BYTES_PER_WORD + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BYTES_PER_WORD - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [PW:0]   Q_FULL   = (PW + 1)'(QDEPTH);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] byte_cnt_r, byte_cnt_nxt_s;
  logic [TW-1:0] tmo_cnt_r, tmo_cnt_nxt_s;
  logic [W-1:0]  shift_r, shift_nxt_s;
  logic          sign_r, sign_nxt_s;
  logic          done_s, tmo_s, pop_s, push_s, drop_s, full_s;

  logic [W:0]    mem_r [QDEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [PW:0]   count_r;
  logic          ovf_r, frame_err_r;

  // Next-state and frame-assembly decode
  always_comb begin
    state_nxt_s    = state_r;
    byte_cnt_nxt_s = byte_cnt_r;
    tmo_cnt_nxt_s  = tmo_cnt_r;
    shift_nxt_s    = shift_r;
    sign_nxt_s     = sign_r;
    done_s         = 1'b0;
    tmo_s          = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.byte_vld) begin
          shift_nxt_s   = W'(bus.byte_in);
          sign_nxt_s    = bus.sign_in;
          tmo_cnt_nxt_s = '0;
          if (BYTES_PER_WORD == 1) begin
            done_s         = 1'b1;
            byte_cnt_nxt_s = '0;
          end else begin
            byte_cnt_nxt_s = CW'(1);
            state_nxt_s    = COLLECT;
          end
        end else begin
          byte_cnt_nxt_s = '0;
        end
      end
      COLLECT: begin
        if (bus.byte_vld) begin
          shift_nxt_s   = (shift_r << 8) | W'(bus.byte_in);
          tmo_cnt_nxt_s = '0;
          if (byte_cnt_r == LAST_CNT) begin
            done_s         = 1'b1;
            byte_cnt_nxt_s = '0;
            state_nxt_s    = IDLE;
          end else begin
            byte_cnt_nxt_s = byte_cnt_r + CW'(1);
          end
        end else if (tmo_cnt_r == TMO_LAST) begin
          tmo_s          = 1'b1;
          byte_cnt_nxt_s = '0;
          tmo_cnt_nxt_s  = '0;
          state_nxt_s    = IDLE;
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r + TW'(1);
        end
      end
      default: begin
        state_nxt_s    = IDLE;
        byte_cnt_nxt_s = '0;
        tmo_cnt_nxt_s  = '0;
      end
    endcase
  end

  // A completed frame may enter a full queue only if the head leaves this cycle
  assign pop_s  = (count_r != '0) && bus.res_ready;
  assign full_s = (count_r == Q_FULL);
  assign push_s = done_s && (!full_s || pop_s);
  assign drop_s = done_s && full_s && !pop_s;

  // FSM and assembly registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      byte_cnt_r  <= '0;
      tmo_cnt_r   <= '0;
      shift_r     <= '0;
      sign_r      <= 1'b0;
      ovf_r       <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      byte_cnt_r  <= byte_cnt_nxt_s;
      tmo_cnt_r   <= tmo_cnt_nxt_s;
      shift_r     <= shift_nxt_s;
      sign_r      <= sign_nxt_s;
      ovf_r       <= drop_s;
      frame_err_r <= tmo_s;
    end
  end

  // Result queue storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {sign_nxt_s, shift_nxt_s};
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PW + 1)'(1);
        2'b01:   count_r <= count_r - (PW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign bus.res_data  = 64'(mem_r[rd_ptr_r][W-1:0]);
  assign bus.res_sign  = mem_r[rd_ptr_r][W];
  assign bus.res_valid = (count_r != '0);
  assign bus.busy      = (state_r == COLLECT);
  assign bus.frame_err = frame_err_r;
  assign bus.ovf       = ovf_r;

`ifdef RESULT_DESER_STATS_EN
  // Saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= 16'h0000;
      drop_cnt  <= 16'h0000;
    end else begin
      if (push_s && (frame_cnt != 16'hFFFF)) begin
        frame_cnt <= frame_cnt + 16'h0001;
      end else begin
        frame_cnt <= frame_cnt;
      end
      if ((drop_s || tmo_s) && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'h0001;
      end else begin
        drop_cnt <= drop_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_result_byte_deser.sv
// Randomized + directed bench for result_byte_deser against a queue-based frame model.
module tb_result_byte_deser;
  localparam int BPW = 8;
  localparam int TMO = 64;
  localparam int QD  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  result_byte_deser_if bus ();
`ifdef RESULT_DESER_STATS_EN
  logic [15:0] frame_cnt, drop_cnt;
`endif

  result_byte_deser #(.BYTES_PER_WORD(BPW), .TIMEOUT_CYC(TMO), .QDEPTH(QD)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef RESULT_DESER_STATS_EN
    ,
    .frame_cnt(frame_cnt),
    .drop_cnt(drop_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Model: list of pending results plus the partially received frame
  logic [64:0] mq[$];
  int          part_n = 0;
  logic [63:0] part_word = 64'h0;
  logic        part_sign = 1'b0;
  int          idle_n = 0;
  logic        m_ovf, m_ferr;
  int          m_fcnt = 0;
  int          m_dcnt = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic bv, input logic [7:0] b, input logic s, input logic rdy);
    bit          pop;
    bit          have_push;
    logic [64:0] ent;
    reset        = rst;
    bus.byte_vld = bv;
    bus.byte_in  = b;
    bus.sign_in  = s;
    bus.res_ready = rdy;
    m_ovf = 1'b0;
    m_ferr = 1'b0;
    have_push = 1'b0;
    ent = '0;
    if (rst) begin
      mq.delete();
      part_n = 0;
      idle_n = 0;
      m_fcnt = 0;
      m_dcnt = 0;
    end else begin
      pop = (mq.size() != 0) && rdy;
      if (bv) begin
        if (part_n == 0) begin
          part_sign = s;
          part_word = 64'h0;
        end
        part_word = {part_word[55:0], b};
        part_n++;
        idle_n = 0;
        if (part_n == BPW) begin
          if (mq.size() - int'(pop) < QD) begin
            have_push = 1'b1;
            ent = {part_sign, part_word};
          end else begin
            m_ovf = 1'b1;
          end
          part_n = 0;
        end
      end else if (part_n > 0) begin
        idle_n++;
        if (idle_n == TMO) begin
          m_ferr = 1'b1;
          part_n = 0;
          idle_n = 0;
        end
      end
      if (pop) void'(mq.pop_front());
      if (have_push) begin
        mq.push_back(ent);
        if (m_fcnt < 65535) m_fcnt++;
      end
      if ((m_ovf || m_ferr) && m_dcnt < 65535) m_dcnt++;
    end
    @(posedge clk);
    #1;
    check_val("res_valid", 64'(bus.res_valid), 64'(mq.size() != 0));
    check_val("busy", 64'(bus.busy), 64'(part_n > 0));
    check_val("frame_err", 64'(bus.frame_err), 64'(m_ferr));
    check_val("ovf", 64'(bus.ovf), 64'(m_ovf));
    if (mq.size() != 0) begin
      check_val("res_data", bus.res_data, mq[0][63:0]);
      check_val("res_sign", 64'(bus.res_sign), 64'(mq[0][64]));
    end
    if (rst) begin
      check_val("rst_data", bus.res_data, 64'h0);
      check_val("rst_sign", 64'(bus.res_sign), 64'h0);
    end
`ifdef RESULT_DESER_STATS_EN
    check_val("frame_cnt", 64'(frame_cnt), 64'(m_fcnt));
    check_val("drop_cnt", 64'(drop_cnt), 64'(m_dcnt));
`endif
  endtask

  // Sends one frame MSB first; sign_in after the first byte is random noise
  task automatic send_frame(input logic [63:0] w, input logic s, input logic rdy, input logic rdy_last);
    for (int i = 0; i < BPW; i++) begin
      cycle(1'b0, 1'b1, w[63-8*i -: 8], (i == 0) ? s : 1'($urandom), (i == BPW - 1) ? rdy_last : rdy);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, rdy);
  endtask

  initial begin
    int pulses;
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'hAA, 1'b1, 1'b1);
    check_val("reset_valid", 64'(bus.res_valid), 64'h0);

    // Single frame with immediate acceptance
    send_frame(64'h123456789ABCDEF0, 1'b1, 1'b1, 1'b1);
    check_val("single_data", bus.res_data, 64'h123456789ABCDEF0);
    check_val("single_sign", 64'(bus.res_sign), 64'h1);
    idle(1, 1'b1);
    check_val("single_fall", 64'(bus.res_valid), 64'h0);

    // Back-to-back frames with the host stalled; third frame overflows
    send_frame(64'hA0A1A2A3A4A5A6A7, 1'b0, 1'b0, 1'b0);
    send_frame(64'hB0B1B2B3B4B5B6B7, 1'b1, 1'b0, 1'b0);
    send_frame(64'hC0C1C2C3C4C5C6C7, 1'b0, 1'b0, 1'b0);
    check_val("ovf_pulse", 64'(bus.ovf), 64'h1);
    check_val("ovf_head", bus.res_data, 64'hA0A1A2A3A4A5A6A7);
    idle(1, 1'b1);
    check_val("pop_b", bus.res_data, 64'hB0B1B2B3B4B5B6B7);
    idle(2, 1'b1);

    // Inter-byte timeout, then a clean frame
    cycle(1'b0, 1'b1, 8'h11, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 8'h22, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 8'h33, 1'b0, 1'b1);
    pulses = 0;
    for (int i = 0; i < TMO + 3; i++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      if (bus.frame_err) pulses++;
    end
    check_val("tmo_pulses", 64'(pulses), 64'h1);
    send_frame(64'h0102030405060708, 1'b0, 1'b1, 1'b1);
    check_val("tmo_clean", bus.res_data, 64'h0102030405060708);
    idle(2, 1'b1);

    // Full-queue push with a simultaneous pop
    send_frame(64'hD0D1D2D3D4D5D6D7, 1'b0, 1'b0, 1'b0);
    send_frame(64'hE0E1E2E3E4E5E6E7, 1'b1, 1'b0, 1'b0);
    send_frame(64'hF0F1F2F3F4F5F6F7, 1'b1, 1'b0, 1'b1);
    check_val("fullpop_ovf", 64'(bus.ovf), 64'h0);
    check_val("fullpop_head", bus.res_data, 64'hE0E1E2E3E4E5E6E7);
    idle(1, 1'b1);
    check_val("fullpop_new", bus.res_data, 64'hF0F1F2F3F4F5F6F7);
    idle(2, 1'b1);

    // Reset mid-frame
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'(8'h50 + i), 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check_val("midrst_busy", 64'(bus.busy), 64'h0);
    send_frame(64'h8877665544332211, 1'b1, 1'b1, 1'b1);
    check_val("midrst_frame", bus.res_data, 64'h8877665544332211);

    // fp32 result word
    send_frame(64'h3FC0000000000000, 1'b0, 1'b1, 1'b1);
    check_val("fp32_data", bus.res_data, 64'h3FC0000000000000);
    idle(2, 1'b1);

    // Randomized traffic in phases of differing density and host readiness
    for (int blk = 0; blk < 40; blk++) begin
      int mode;
      int pv;
      int pr;
      mode = $urandom_range(0, 3);
      case (mode)
        0: begin pv = 95;  pr = 50;  end
        1: begin pv = 60;  pr = 90;  end
        2: begin pv = 2;   pr = 10;  end
        default: begin pv = 100; pr = 100; end
      endcase
      for (int i = 0; i < 100; i++) begin
        cycle(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 99) < pv),
              8'($urandom), 1'($urandom), 1'($urandom_range(0, 99) < pr));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/result_byte_deser.md
Name: result_byte_deser

Overview:
- Downstream stage of the divider/fp32 datapath top.
- Consumes the 8-bit result stream leaving the output FIFO (byte, per-byte strobe, sign) and reassembles 64-bit result words: {q,r} for divr2, {fp32,32'b0} for fp32.
- Delivers each result with its sign to the host through a valid/ready port.
- Has a 2-entry result queue, an inter-byte timeout and overflow detection, because the byte stream has no backpressure.

Parameters:
- BYTES_PER_WORD, 8, bytes per result word; word width = 8*BYTES_PER_WORD.
- TIMEOUT_CYC, 64, idle cycles allowed between bytes of one frame before the partial frame is discarded.
- QDEPTH, 2, result queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- byte_in  in  8  result byte from the output FIFO
- byte_vld  in  1  byte strobe, one byte per cycle when high
- sign_in  in  1  result sign accompanying the byte stream
- res_data  out  64  assembled word; the first byte received is bits [63:56]
- res_sign  out  1  sign of the head result
- res_valid  out  1  head of queue valid
- res_ready  in  1  host accepts the head when res_valid && res_ready
- busy  out  1  a frame is partially collected
- frame_err  out  1  one-cycle pulse on timeout discard
- ovf  out  1  one-cycle pulse when a completed frame is dropped because the queue is full

Behaviour:
- Reset (reset=1 at a clk edge) drives res_data=0, res_sign=0, res_valid=0, busy=0, frame_err=0, ovf=0. It clears the queue pointers and count, the byte counter, the timeout counter, and the state (to IDLE). This applies mid-frame and mid-handshake; the partial frame is lost with no error pulse.
- FSM states: IDLE and COLLECT.
- IDLE:
  - byte_vld=1: load byte_in into the shift register, latch sign_in as the frame sign, set byte_cnt=1, go to COLLECT.
  - Exception: if BYTES_PER_WORD==1 the frame completes at once.
- COLLECT:
  - Each byte_vld shifts the byte in (left shift, new byte in the LSBs), increments byte_cnt and clears the timeout counter.
  - sign_in is ignored after the first byte.
  - Without byte_vld, the timeout counter increments.
- Frame completion (the byte_vld cycle with byte_cnt==BYTES_PER_WORD-1):
  - If the queue is not full, or a pop happens in the same cycle, write {sign, word} to the queue at the next edge.
  - Otherwise drop the frame and pulse ovf on the next cycle.
  - Either way, return to IDLE with byte_cnt=0.
  - A byte arriving in the cycle after completion starts a new frame. Back-to-back frames at one byte per cycle are supported.
- Timeout: when the timeout counter reaches TIMEOUT_CYC-1 while no byte is present, discard the partial frame, pulse frame_err for 1 cycle and go to IDLE.
- busy = (state==COLLECT).
- Queue:
  - FIFO order with QDEPTH entries and registered outputs.
  - res_valid = (count!=0); res_data and res_sign present the head entry.
  - Latency is 1 cycle from the edge that captures the last byte to res_valid=1.
  - The head is held stable until accepted.
- Pop and push in the same cycle are both allowed, and count is unchanged.
- Push into a full queue with a simultaneous pop succeeds, with no ovf.
- Pointers wrap modulo QDEPTH.
- res_ready while res_valid=0 is ignored.

Optional Feature:
- Macro: RESULT_DESER_STATS_EN.
- When defined:
  - Adds output frame_cnt[15:0], counting frames enqueued.
  - Adds output drop_cnt[15:0], counting ovf and frame_err events combined.
  - Both counters saturate at 16'hFFFF and clear on reset.
- When undefined, these ports and registers do not exist, and all other behaviour is identical.

Test Plan:
- Single frame: bytes 12 34 56 78 9A BC DE F0 on consecutive cycles with sign_in=1 at the first byte, res_ready=1 -> res_valid rises 1 cycle after the last byte, res_data=64'h123456789ABCDEF0, res_sign=1, then falls after 1 cycle.
- Backpressure and overflow: res_ready=0, 3 back-to-back frames A, B, C -> A and B are queued; C is dropped with an ovf pulse; raising res_ready pops A then B in order; drop_cnt=1 when stats are enabled.
- Timeout: 3 bytes, then no byte_vld for 64 cycles -> frame_err pulses once, busy=0; the next 8 bytes form a correct word with no stale bytes.
- Full-queue push with pop: queue full, res_ready=1 in the cycle a frame completes -> no ovf, count stays 2, and the new word arrives after the existing entries.
- Reset mid-frame: 5 bytes, then reset=1 for 1 cycle -> all outputs 0, no frame_err; the following full frame is assembled correctly.
- fp32 result: bytes 3F C0 00 00 00 00 00 00 -> res_data=64'h3FC0000000000000.
